// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared constants for the nibble-serial adder sequencer: state encoding and nibble width.
package nibble_serial_adder_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/nibble_serial_adder_ctrl_rca.sv
// 4-bit ripple-carry adder shared by the serial sequencer; purely combinational.
module ripplecarryadder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic       cout,
    output logic [3:0] s
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds/subtracts two WIDTH-bit operands one nibble per clock, LSB first, on a single 4-bit adder.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [31:0]      base;
    logic [NIB_W-1:0] nib_a, nib_b, nib_s;
    logic             add_co;
    logic             accept;

    assign base  = 32'(idx_q) * 32'(NIB_W);
    assign nib_a = op_a_q[base +: NIB_W];
    assign nib_b = op_b_q[base +: NIB_W];

    ripplecarryadder u_rca (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .cout (add_co),
        .s    (nib_s)
    );

    // Starts are only honoured when no operation is in flight.
    assign accept = start && (state_q != S_RUN);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_RUN: begin
                sum_d[base +: NIB_W] = nib_s;
                carry_d = add_co;
                if (idx_q == IDX_LAST) begin
                    cout_d  = add_co;
                    ovf_d   = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) && (nib_s[NIB_W-1] != op_a_q[WIDTH-1]);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            state_d = S_RUN;
            op_a_d  = a;
            op_b_d  = sub ? ~b : b;
            carry_d = sub ? 1'b1 : cin;
            idx_d   = '0;
            sum_d   = '0;
            cout_d  = 1'b0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for the nibble-serial adder: arithmetic reference model plus literal result checks.
module tb_nibble_serial_adder_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int tests = 0;
    int fails = 0;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference: whole-word arithmetic, independent of nibble sequencing.
    function automatic logic [WIDTH:0] ref_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic c, input logic s);
        logic [WIDTH-1:0] yy;
        yy = s ? ~y : y;
        return {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, (s ? 1'b1 : c)};
    endfunction

    function automatic logic ref_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic c, input logic s);
        logic [WIDTH-1:0] yy;
        logic [WIDTH:0]   r;
        yy = s ? ~y : y;
        r  = ref_res(x, y, c, s);
        return (x[WIDTH-1] == yy[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Phase: 0 idle, 1..NIB running (phase-1 nibbles already written), NIB+1 done.
    int               m_phase;
    logic [WIDTH:0]   m_res;
    logic             m_ovf_full;
    logic [WIDTH-1:0] m_sum;
    logic             m_cout;
    logic             m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_sum   <= '0;
            m_cout  <= 1'b0;
            m_ovf   <= 1'b0;
        end else if (m_phase >= 1 && m_phase <= NIB) begin
            m_sum   <= WIDTH'(64'(m_res) & ((64'd1 << (4 * m_phase)) - 64'd1));
            if (m_phase == NIB) begin
                m_cout <= m_res[WIDTH];
                m_ovf  <= m_ovf_full;
            end
            m_phase <= m_phase + 1;
        end else if (start) begin
            m_res      <= ref_res(a, b, cin, sub);
            m_ovf_full <= ref_ovf(a, b, cin, sub);
            m_sum      <= '0;
            m_cout     <= 1'b0;
            m_ovf      <= 1'b0;
            m_phase    <= 1;
        end else begin
            m_phase <= 0;
        end
    end

    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_outputs",
                  64'({busy, done, cout, ovf, sum}),
                  64'({(m_phase >= 1 && m_phase <= NIB), (m_phase == NIB + 1), m_cout, m_ovf, m_sum}));
        end
    end

    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tc, input logic ts);
        a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
    endtask

    // Called right after issue() at a negedge; returns at the negedge where done is seen.
    task automatic wait_done(output int n, output int nbusy);
        n = 0; nbusy = 0;
        @(negedge clk); start = 1'b0; n = 1;
        while (!done && n < 20) begin
            if (busy) nbusy++;
            @(negedge clk); n++;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL done_timeout: no done after %0d cycles", n);
        end
    endtask

    task automatic run_op(input string nm, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                          input logic tc, input logic ts,
                          input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        int n, nb;
        @(negedge clk);
        issue(ta, tb_, tc, ts);
        wait_done(n, nb);
        check({nm, "_latency"}, 64'(n), 64'd5);
        check({nm, "_busy_cycles"}, 64'(nb), 64'd4);
        check({nm, "_sum"}, 64'(sum), 64'(es));
        check({nm, "_cout"}, 64'(cout), 64'(ec));
        check({nm, "_ovf"}, 64'(ovf), 64'(eo));
    endtask

    initial begin
        int n, nb, dcnt;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        check("reset_outputs", 64'({busy, done, cout, ovf, sum}), 64'd0);
        @(negedge clk); rst = 1'b0;
        chk_en = 1'b1;

        run_op("add_basic",   16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("ripple",      16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("ripple_cin",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("add_cin",     16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);

        // start held through RUN with changing operands: only the first op counts.
        @(negedge clk);
        issue(16'h0101, 16'h0202, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 16'hAAAA + 16'(i); b = 16'h1111;
        end
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("held_start_done", 64'(done), 64'd1);
        check("held_start_sum", 64'(sum), 64'h0303);

        // Back-to-back: new start in the DONE cycle.
        @(negedge clk);
        issue(16'h1000, 16'h2000, 1'b0, 1'b0);
        wait_done(n, nb);
        issue(16'h0009, 16'h0003, 1'b0, 1'b1);
        wait_done(n, nb);
        check("b2b_latency", 64'(n), 64'd5);
        check("b2b_sum", 64'(sum), 64'h0006);
        check("b2b_cout", 64'(cout), 64'd1);

        // Reset two cycles into an operation.
        @(negedge clk);
        issue(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(negedge clk); start = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        #1 check("reset_mid_op", 64'({busy, done, cout, ovf, sum}), 64'd0);
        @(negedge clk); rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("no_done_after_reset", 64'(dcnt), 64'd0);
        run_op("after_reset", 16'h2222, 16'h3333, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
